lsu_bus_if: RTL and testbench
=============================

# lsu_bus_if

Load/store responder for the 3-stage RISC-V pipeline. It consumes the decoder's memory controls (`read_en`, `write_en`, `funct3`) with the ALU address and rs2 data, and runs one word-aligned request/acknowledge transaction on the data-memory bus. It returns sign- or zero-extended load data to writeback and holds the pipeline stalled until the access completes, is rejected or times out.

## Interface
- `TIMEOUT`, 255: maximum cycles to wait for `bus_ack` before aborting; range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `read_en` in 1: load request from the decoder.
- `write_en` in 1: store request from the decoder.
- `funct3` in 3: access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `rdata` out 32: extended load data, valid while `done`=1.
- `done` out 1: one-cycle pulse when a transaction completes successfully.
- `stall` out 1: combinational; freezes PC and pipeline registers.
- `misalign` out 1: one-cycle pulse when an access is rejected as misaligned.
- `bus_err` out 1: one-cycle pulse when the bus times out.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: store data replicated across byte lanes.
- `bus_ack` in 1: bus completion strobe.
- `bus_rdata` in 32: read word, valid with `bus_ack`.

## Operation
- **Command selection**
  - `write_en`=1 selects a store; `write_en` has priority over `read_en` if both are high.
  - `read_en`=1 alone selects a load.
- **Size mapping**
  - funct3[1:0]=00: byte.
  - funct3[1:0]=01: half.
  - Any other value: word.
  - funct3[2]=1 on a load: zero-extend; otherwise sign-extend. funct3[2] is ignored for stores.
- **Alignment**
  - A half access requires `addr[0]`=0.
  - A word access requires `addr[1:0]`=00.
  - Byte accesses are always aligned.
- **Byte enables**
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `4'b0011<<{addr[1],1'b0}`.
  - Word: `4'b1111`.
- **Store data**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
- **Load extraction:** select the byte lane by `addr[1:0]` or the half lane by `addr[1]` from `bus_rdata`, then extend per funct3[2]. The address, size and sign are latched at issue.
- **FSM states:** IDLE, REQ, DONE.
  - **IDLE**, request present and aligned: latch the command, go to REQ, `stall`=1.
  - **IDLE**, request present and misaligned: pulse `misalign`, stay in IDLE, `stall`=0, no bus activity.
  - **IDLE**, no request: stay in IDLE, `stall`=0.
  - **REQ**: `bus_req`=1, with `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` held stable, `stall`=1.
    - `bus_ack`=1: capture the extended data into `rdata`, go to DONE.
    - Wait counter reaches `TIMEOUT`: go to IDLE, pulse `bus_err`, `rdata`=0, `stall`=0 in the exit cycle.
  - **DONE**: `done`=1, `stall`=0 so the pipeline advances. Inputs are ignored, so the same instruction is never re-issued. Next state is IDLE.
- **Reset:** all outputs are 0 and the state is IDLE. An asserted `rst_n` mid-transaction drops `bus_req` immediately (asynchronously) and clears the counter.
- **Late acknowledge:** a `bus_ack` seen outside REQ is ignored.

## Timing
- **Request timing:** `bus_req` rises on the edge after the IDLE accept and falls on the edge after `bus_ack` is sampled.
- **Load latency:** accept to `done` is 2 + N cycles, where N is the number of wait cycles before `bus_ack`. The minimum is 2 cycles (ack in the first REQ cycle).
- **Wait counter:** 8 bits, zeroed on entry to REQ and incremented each REQ cycle without ack.
  - With `TIMEOUT`=T, the abort happens on the T-th cycle without ack.
  - An ack and the timeout in the same cycle: the ack wins.
- **Stall equation:** `stall` = (IDLE & (`read_en`|`write_en`) & aligned) | REQ.
  - It is combinational from the inputs and state.
  - It has no combinational path from `bus_ack`.

## Structure
- **`DEFS.svh` additions**
  - `lsu_state_t` enum (S_IDLE, S_REQ, S_DONE).
  - funct3 constants `f3_b`, `f3_h`, `f3_w`, `f3_bu`, `f3_hu`, alongside `type_opcode`.
- **Sub-module `lsu_load_align`** (combinational): inputs `bus_rdata`, latched `addr[1:0]`, size and sign; output the 32-bit extended result.

## Test plan
- **LW with ack after 3 waits:** `addr`=0x100, `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111, `rdata`=0xDEADBEEF, `done` on cycle 5 after accept, `stall` high for 4 cycles.
- **LB and LBU:** `addr`=0x103, `bus_rdata`=0x80FF_0000 → LB gives `rdata`=0xFFFFFF80; LBU gives `rdata`=0x00000080.
- **SH:** `addr`=0x22, `wdata`=0x1234ABCD → `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_addr`=0x20.
- **Misaligned LW:** `addr`=0x102 → `misalign` pulse, `bus_req` stays 0, `stall`=0.
- **Timeout:** `TIMEOUT`=4 and no ack → `bus_err` pulse after 4 REQ cycles, then IDLE with `rdata`=0; a later stray `bus_ack` has no effect.
- **Reset mid-REQ:** drop `rst_n` during REQ → `bus_req` goes 0 immediately; after release a new SW completes normally.

Source files
------------

// File: rtl/lsu_bus_if_pkg.sv
// rtl/lsu_bus_if_pkg.sv - shared types, funct3 constants and helpers for the load/store bus interface
// Contents: lsu_state_t (FSM states), lsu_size_t (access size), type_opcode,
//           funct3 constants f3_*, size decode and alignment helpers.
package lsu_bus_if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011
    } type_opcode;

    localparam logic [2:0] f3_b  = 3'b000;
    localparam logic [2:0] f3_h  = 3'b001;
    localparam logic [2:0] f3_w  = 3'b010;
    localparam logic [2:0] f3_bu = 3'b100;
    localparam logic [2:0] f3_hu = 3'b101;

    // funct3[1:0] = 11 is not a legal RV32 size; it is treated as a word.
    function automatic lsu_size_t size_of(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   size_of = SZ_B;
            2'b01:   size_of = SZ_H;
            default: size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_aligned(input lsu_size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = ~a[0];
            default: is_aligned = (a == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_if_load_align.sv
// rtl/lsu_bus_if_load_align.sv - selects the addressed byte/half lane of a read word and extends it
// Ports: i_bus_rdata (raw bus word), i_addr_lo (latched addr[1:0]), i_size (latched size),
//        i_unsigned (1 = zero-extend), o_data (extended 32-bit load result).
module lsu_load_align
    import lsu_bus_if_pkg::*;
(
    input  logic [31:0] i_bus_rdata,
    input  logic [1:0]  i_addr_lo,
    input  lsu_size_t   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_bus_rdata[7:0];
        case (i_addr_lo)
            2'b00:   w_byte = i_bus_rdata[7:0];
            2'b01:   w_byte = i_bus_rdata[15:8];
            2'b10:   w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

        case (i_size)
            SZ_B:    o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_H:    o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_bus_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - load/store responder running one word-aligned req/ack bus transaction per access
// Ports: i_clk/i_rst_n (clock, async active-low reset); i_read_en/i_write_en/i_funct3/i_addr/i_wdata
//        (decoder command); o_rdata/o_done/o_stall/o_misalign/o_bus_err (pipeline side);
//        o_bus_req/o_bus_we/o_bus_addr/o_bus_be/o_bus_wdata, i_bus_ack/i_bus_rdata (memory bus).
module lsu_bus_if
    import lsu_bus_if_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    // Abort on the TIMEOUT-th ack-less cycle: counter holds the number of earlier misses.
    localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_addr_lo;
    lsu_size_t   r_size;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_misalign;
    logic        r_bus_err;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic        w_req;
    lsu_size_t   w_size;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_req     = i_read_en | i_write_en;
    assign w_size    = size_of(i_funct3[1:0]);
    assign w_aligned = is_aligned(w_size, i_addr[1:0]);

    always_comb begin
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .i_bus_rdata (i_bus_rdata),
        .i_addr_lo   (r_addr_lo),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .o_data      (w_load_data)
    );

    // Depends only on state and decoder inputs, never on i_bus_ack.
    assign o_stall = ((r_state == S_IDLE) && w_req && w_aligned) || (r_state == S_REQ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr_lo   <= '0;
            r_size      <= SZ_B;
            r_unsigned  <= 1'b0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_aligned) begin
                            r_state     <= S_REQ;
                            r_cnt       <= '0;
                            r_addr_lo   <= i_addr[1:0];
                            r_size      <= w_size;
                            r_unsigned  <= ~i_write_en & i_funct3[2];
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= i_write_en;
                            r_bus_addr  <= {i_addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                        end else begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (i_bus_ack) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= r_bus_we ? 32'h0 : w_load_data;
                    end else if (r_cnt == C_LAST) begin
                        r_state   <= S_IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_misalign  = r_misalign;
    assign o_bus_err   = r_bus_err;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb/tb_lsu_bus_if.sv - table-driven scoreboard bench for lsu_bus_if
module tb_lsu_bus_if;

    localparam int TO = 4;
    localparam int K_DONE = 0;
    localparam int K_MIS  = 1;
    localparam int K_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          waits;
        int          kind;
        int          lat;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];
    vec_t sb[$];

    lsu_bus_if #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_read_en   (read_en),
        .i_write_en  (write_en),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_done      (done),
        .o_stall     (stall),
        .o_misalign  (misalign),
        .o_bus_err   (bus_err),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_be    (bus_be),
        .o_bus_wdata (bus_wdata),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic re, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                                input int waits, input int kind, input logic [31:0] baddr,
                                input logic [3:0] be, input logic [31:0] bwd, input logic [31:0] rd);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.brd = brd;
        v.waits = waits; v.kind = kind;
        v.lat = (kind == K_MIS) ? 1 : (kind == K_ERR) ? TO + 1 : waits + 2;
        v.exp_baddr = baddr; v.exp_be = be; v.exp_we = we; v.exp_bwdata = bwd; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic run(input int idx, input vec_t v);
        int   k;
        bit   seen;
        int   act_kind;
        vec_t e;
        @(negedge clk);
        read_en = v.re; write_en = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        bus_rdata = v.brd;
        sb.push_back(v);
        #1;
        chk("stall_at_issue", idx, 32'(stall), 32'(v.kind != K_MIS));
        @(posedge clk); #1;
        read_en = 1'b0; write_en = 1'b0;
        k = 1; seen = 0;
        while (!seen && k < 20) begin
            if (done || misalign || bus_err) begin
                seen = 1;
            end else begin
                chk("bus_req", idx, 32'(bus_req), 32'h1);
                chk("stall_req", idx, 32'(stall), 32'h1);
                chk("bus_addr", idx, bus_addr, v.exp_baddr);
                chk("bus_be", idx, 32'(bus_be), 32'(v.exp_be));
                chk("bus_we", idx, 32'(bus_we), 32'(v.exp_we));
                if (v.exp_we) chk("bus_wdata", idx, bus_wdata, v.exp_bwdata);
                bus_ack = (k - 1 == v.waits);
                @(posedge clk); #1;
                bus_ack = 1'b0;
                k++;
            end
        end
        if (!seen) begin
            chk("no_completion", idx, 32'h0, 32'h1);
        end else if (sb.size() == 0) begin
            chk("scoreboard_empty", idx, 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            act_kind = done ? K_DONE : misalign ? K_MIS : K_ERR;
            chk("result_kind", idx, 32'(act_kind), 32'(e.kind));
            chk("latency", idx, 32'(k), 32'(e.lat));
            chk("bus_req_after", idx, 32'(bus_req), 32'h0);
            chk("stall_after", idx, 32'(stall), 32'h0);
            if (e.kind == K_ERR || (e.kind == K_DONE && !e.we))
                chk("rdata", idx, rdata, e.exp_rdata);
        end
        @(posedge clk); #1;
        chk("pulse_one_cycle", idx, 32'({done, misalign, bus_err}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            re    we    f3      addr          wdata         brd           w   kind    baddr         be       bwdata        rdata
        vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3,  K_DONE, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0,  K_DONE, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0,  K_DONE, 32'h100, 4'b1000, 32'h0,        32'h00000080);
        vecs[3]  = mk(1'b0, 1'b1, 3'b001, 32'h22,  32'h1234ABCD, 32'h0,        1,  K_DONE, 32'h20,  4'b1100, 32'hABCDABCD, 32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1,  K_DONE, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001);
        vecs[5]  = mk(1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h0000F00F, 2,  K_DONE, 32'h100, 4'b0011, 32'h0,        32'h0000F00F);
        vecs[6]  = mk(1'b0, 1'b1, 3'b000, 32'h41,  32'h000000A5, 32'h0,        0,  K_DONE, 32'h40,  4'b0010, 32'hA5A5A5A5, 32'h0);
        vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h80,  32'h01234567, 32'h0,        2,  K_DONE, 32'h80,  4'b1111, 32'h01234567, 32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0,  K_MIS,  32'h0,   4'b0000, 32'h0,        32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 3'b001, 32'h21,  32'h0,        32'h0,        0,  K_MIS,  32'h0,   4'b0000, 32'h0,        32'h0);
        vecs[10] = mk(1'b1, 1'b1, 3'b010, 32'h10,  32'hCAFEF00D, 32'h0,        0,  K_DONE, 32'h10,  4'b1111, 32'hCAFEF00D, 32'h0);
        vecs[11] = mk(1'b1, 1'b0, 3'b011, 32'h104, 32'h0,        32'h11223344, 1,  K_DONE, 32'h104, 4'b1111, 32'h0,        32'h11223344);
        vecs[12] = mk(1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0,  K_DONE, 32'h100, 4'b0010, 32'h0,        32'h0000007F);
        vecs[13] = mk(1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'h0,        99, K_ERR,  32'h200, 4'b1111, 32'h0,        32'h0);
        vecs[14] = mk(1'b0, 1'b1, 3'b010, 32'h44,  32'h5A5A0F0F, 32'h0,        2,  K_DONE, 32'h44,  4'b1111, 32'h5A5A0F0F, 32'h0);
        // The wdata of the first SB vector is replicated from its low byte only.
        vecs[6].wdata = 32'hFFFFFFA5;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bus_req", 0, 32'(bus_req), 32'h0);
        chk("reset_done", 0, 32'({done, misalign, bus_err}), 32'h0);
        chk("reset_rdata", 0, rdata, 32'h0);
        chk("reset_bus_addr", 0, bus_addr, 32'h0);
        chk("reset_stall", 0, 32'(stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(i, vecs[i]);

        // Stray ack after the timeout: no completion, no bus activity, rdata stays cleared.
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #1;
        chk("stray_ack_done", 0, 32'(done), 32'h0);
        chk("stray_ack_req", 0, 32'(bus_req), 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("stray_ack_rdata", 0, rdata, 32'h0);
        chk("stray_ack_stall", 0, 32'(stall), 32'h0);

        // Reset asserted during REQ drops bus_req without waiting for a clock edge.
        @(negedge clk);
        read_en = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        read_en = 1'b0;
        chk("mid_req_bus_req", 0, 32'(bus_req), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_bus_req", 0, 32'(bus_req), 32'h0);
        chk("async_reset_stall", 0, 32'(stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(14, vecs[14]);

        chk("scoreboard_drained", 0, 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
